// File: rtl/sprite_mover_if.sv
// sprite_mover_if: request handshake plus VGA pixel stream and sprite position.
// master = game control side, slave = the mover.
interface sprite_mover_if #(
    parameter int XW = 8,
    parameter int YW = 7
) ();
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_dir;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [2:0]    colour;
    logic          plot;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          done;
    modport master (
        output req_valid, req_dir,
        input  req_ready, x_out, y_out, colour, plot, pos_x, pos_y, done
    );
    modport slave (
        input  req_valid, req_dir,
        output req_ready, x_out, y_out, colour, plot, pos_x, pos_y, done
    );
endinterface

// File: rtl/sprite_mover.sv
// sprite_mover: on each request erases the sprite, steps it with on-screen clamping,
// and redraws it, streaming one VGA pixel per cycle.
module sprite_mover #(
    parameter int         SPRITE_W  = 4,
    parameter int         SPRITE_H  = 4,
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter int         XW        = 8,
    parameter int         YW        = 7,
    parameter int         STEP      = 1,
    parameter int         X_INIT    = 50,
    parameter int         Y_INIT    = 50,
    parameter logic [2:0] FG_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input logic           clk,
    input logic           reset,
    sprite_mover_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;
    localparam logic [XW:0] XSTEP    = (XW+1)'(STEP);
    localparam logic [XW:0] XMAX     = (XW+1)'(SCREEN_W - SPRITE_W);
    localparam logic [YW:0] YSTEP    = (YW+1)'(STEP);
    localparam logic [YW:0] YMAX     = (YW+1)'(SCREEN_H - SPRITE_H);
    localparam logic [3:0]  COL_LAST = 4'(SPRITE_W - 1);
    localparam logic [3:0]  ROW_LAST = 4'(SPRITE_H - 1);

    state_t        state;
    logic          drawn;
    logic [3:0]    dir, col, row, ncol, nrow;
    logic          last;
    logic [XW:0]   xw;
    logic [YW:0]   yw;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    // Clamp arithmetic is one bit wider than the coordinates so it never wraps.
    always_comb begin
        last = col == COL_LAST && row == ROW_LAST;
        ncol = col == COL_LAST ? 4'd0 : col + 4'd1;
        nrow = col == COL_LAST ? row + 4'd1 : row;
        xw   = {1'b0, bus.pos_x};
        yw   = {1'b0, bus.pos_y};
        nx   = dir[1] == dir[0] ? bus.pos_x
             : dir[1] ? (xw >= XSTEP ? XW'(xw - XSTEP) : '0)
             : (xw + XSTEP <= XMAX ? XW'(xw + XSTEP) : XW'(XMAX));
        ny   = dir[3] == dir[2] ? bus.pos_y
             : dir[3] ? (yw >= YSTEP ? YW'(yw - YSTEP) : '0)
             : (yw + YSTEP <= YMAX ? YW'(yw + YSTEP) : YW'(YMAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            drawn         <= 1'b0;
            dir           <= '0;
            col           <= '0;
            row           <= '0;
            bus.req_ready <= 1'b1;
            bus.plot      <= 1'b0;
            bus.done      <= 1'b0;
            bus.x_out     <= '0;
            bus.y_out     <= '0;
            bus.colour    <= BG_COLOUR;
            bus.pos_x     <= XW'(X_INIT);
            bus.pos_y     <= YW'(Y_INIT);
        end else begin
            bus.plot <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    dir           <= bus.req_dir;
                    bus.req_ready <= 1'b0;
                    col           <= '0;
                    row           <= '0;
                    bus.x_out     <= bus.pos_x;
                    bus.y_out     <= bus.pos_y;
                    bus.colour    <= BG_COLOUR;
                    bus.plot      <= drawn;
                    state         <= drawn ? ERASE : MOVE;
                end
                ERASE, DRAW: if (last) begin
                    state    <= state == ERASE ? MOVE : DONE;
                    bus.done <= state == DRAW;
                    if (state == DRAW) drawn <= 1'b1;
                end else begin
                    col       <= ncol;
                    row       <= nrow;
                    bus.x_out <= bus.pos_x + XW'(ncol);
                    bus.y_out <= bus.pos_y + YW'(nrow);
                    bus.plot  <= 1'b1;
                end
                MOVE: begin
                    state      <= DRAW;
                    bus.pos_x  <= nx;
                    bus.pos_y  <= ny;
                    col        <= '0;
                    row        <= '0;
                    bus.x_out  <= nx;
                    bus.y_out  <= ny;
                    bus.colour <= FG_COLOUR;
                    bus.plot   <= 1'b1;
                end
                DONE: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed vectors for the default mover plus two STEP=3 movers
// sitting against the screen edges.
module tb_sprite_mover;
    localparam int W  = 4;
    localparam int P  = 16;
    localparam int FG = 4;
    localparam int BG = 0;

    typedef struct {
        logic [3:0] dir;
        int ex, ey, lat;
    } vec_a_t;
    typedef struct {
        logic [3:0] db, dc;
        int bx, by, cx, cy, lat;
    } vec_bc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int px = 50, py = 50;
    bit drawn = 1'b0;

    sprite_mover_if #(.XW(8), .YW(7)) ia ();
    sprite_mover_if #(.XW(8), .YW(7)) ib ();
    sprite_mover_if #(.XW(8), .YW(7)) ic ();

    sprite_mover dut_a (.clk(clk), .reset(rst), .bus(ia));
    sprite_mover #(.STEP(3), .X_INIT(156), .Y_INIT(0))   dut_b (.clk(clk), .reset(rst), .bus(ib));
    sprite_mover #(.STEP(3), .X_INIT(2),   .Y_INIT(115)) dut_c (.clk(clk), .reset(rst), .bus(ic));

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic move_a(input logic [3:0] d, input int ex, input int ey, input int lat);
        int k, idx, ix, iy, ec, km;
        bit er, ep;
        er = drawn;
        km = er ? P + 1 : 1;
        @(negedge clk);
        ia.req_valid = 1'b1;
        ia.req_dir   = d;
        @(posedge clk); #1;
        ia.req_valid = 1'b0;
        k = 1;
        while (!ia.done && k <= 2 * P + 2) begin
            ep = 1'b0; idx = 0; ix = 0; iy = 0; ec = 0;
            if (er && k <= P) begin
                ep = 1'b1; idx = k - 1; ix = px; iy = py; ec = BG;
            end else if (k > km && k <= km + P) begin
                ep = 1'b1; idx = k - km - 1; ix = ex; iy = ey; ec = FG;
            end
            chk("plot", ia.plot, ep);
            if (ep) begin
                chk("x_out", ia.x_out, ix + idx % W);
                chk("y_out", ia.y_out, iy + idx / W);
                chk("colour", ia.colour, ec);
            end
            chk("ready_busy", ia.req_ready, 0);
            chk("pos_x_stable", ia.pos_x, k <= km ? px : ex);
            @(posedge clk); #1;
            k++;
        end
        chk("latency", k, lat);
        chk("pos_x", ia.pos_x, ex);
        chk("pos_y", ia.pos_y, ey);
        @(posedge clk); #1;
        chk("done_one_cycle", ia.done, 0);
        chk("ready_idle", ia.req_ready, 1);
        px = ex; py = ey; drawn = 1'b1;
    endtask

    task automatic move_bc(input vec_bc_t v);
        int k;
        @(negedge clk);
        ib.req_valid = 1'b1; ib.req_dir = v.db;
        ic.req_valid = 1'b1; ic.req_dir = v.dc;
        @(posedge clk); #1;
        ib.req_valid = 1'b0;
        ic.req_valid = 1'b0;
        k = 1;
        while (!ib.done && k <= 2 * P + 2) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b_latency", k, v.lat);
        chk("c_done", ic.done, 1);
        chk("b_pos_x", ib.pos_x, v.bx);
        chk("b_pos_y", ib.pos_y, v.by);
        chk("c_pos_x", ic.pos_x, v.cx);
        chk("c_pos_y", ic.pos_y, v.cy);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_a_t  ta[7];
        vec_bc_t tbc[5];
        int nd, d1, d2;
        ta[0] = '{4'b0001, 51, 50, 18};
        ta[1] = '{4'b1000, 51, 49, 34};
        ta[2] = '{4'b0011, 51, 49, 34};
        ta[3] = '{4'b1001, 52, 48, 34};
        ta[4] = '{4'b0000, 52, 48, 34};
        ta[5] = '{4'b0110, 51, 49, 34};
        ta[6] = '{4'b1100, 51, 49, 34};
        tbc[0] = '{4'b0001, 4'b0010, 156, 0, 0, 115, 18};
        tbc[1] = '{4'b1000, 4'b0100, 156, 0, 0, 116, 34};
        tbc[2] = '{4'b0010, 4'b0001, 153, 0, 3, 116, 34};
        tbc[3] = '{4'b0100, 4'b1000, 153, 3, 3, 113, 34};
        tbc[4] = '{4'b1001, 4'b0110, 156, 0, 0, 116, 34};
        ia.req_valid = 1'b0; ia.req_dir = '0;
        ib.req_valid = 1'b0; ib.req_dir = '0;
        ic.req_valid = 1'b0; ic.req_dir = '0;

        repeat (3) @(posedge clk); #1;
        chk("rst_ready", ia.req_ready, 1);
        chk("rst_plot", ia.plot, 0);
        chk("rst_done", ia.done, 0);
        chk("rst_x_out", ia.x_out, 0);
        chk("rst_y_out", ia.y_out, 0);
        chk("rst_colour", ia.colour, BG);
        chk("rst_pos_x", ia.pos_x, 50);
        chk("rst_pos_y", ia.pos_y, 50);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) move_bc(tbc[i]);
        for (int i = 0; i < 7; i++) move_a(ta[i].dir, ta[i].ex, ta[i].ey, ta[i].lat);

        // req_valid held high: one acceptance per IDLE, done at 34 and 69
        @(negedge clk);
        ia.req_valid = 1'b1;
        ia.req_dir   = 4'b0001;
        @(posedge clk); #1;
        nd = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 69; k++) begin
            if (ia.done) begin
                nd++;
                if (nd == 1) d1 = k; else d2 = k;
            end
            if (k < 69) begin
                @(posedge clk); #1;
            end
        end
        ia.req_valid = 1'b0;
        chk("hold_dones", nd, 2);
        chk("hold_done1", d1, 34);
        chk("hold_done2", d2, 69);
        nd = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ia.done) nd++;
        end
        chk("hold_extra_done", nd, 0);
        chk("hold_pos_x", ia.pos_x, px + 2);
        chk("hold_ready", ia.req_ready, 1);
        px = px + 2;

        // reset during DRAW, then the next request skips erase
        @(negedge clk);
        ia.req_valid = 1'b1;
        ia.req_dir   = 4'b0100;
        @(posedge clk); #1;
        ia.req_valid = 1'b0;
        repeat (P + 4) @(posedge clk);
        #1;
        chk("mid_draw_plot", ia.plot, 1);
        chk("mid_draw_colour", ia.colour, FG);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_plot", ia.plot, 0);
        chk("abort_ready", ia.req_ready, 1);
        chk("abort_done", ia.done, 0);
        chk("abort_pos_x", ia.pos_x, 50);
        chk("abort_pos_y", ia.pos_y, 50);
        rst = 1'b0;
        px = 50; py = 50; drawn = 1'b0;
        move_a(4'b0001, 51, 50, 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
